// File: rtl/pll_rstseq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// Optional status counters are enabled with PLL_RSTSEQ_STATUS_EN.
package pll_rstseq_pkg;

    // Sequencer states; the encoding is fixed so that it reads the same in a waveform viewer.
    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    // Width of the saturating retry / loss counters.
    localparam int STATUS_W = 8;

    // Counter width: enough bits for the largest terminal count, plus one.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and its surroundings.
// The retry_count / loss_count members exist only with PLL_RSTSEQ_STATUS_EN.
interface pll_reset_sequencer_if;
    import pll_rstseq_pkg::*;

    logic pll_locked;   // raw PLL LOCK, asynchronous to the sequencer clock
    logic rst_req;      // single-cycle soft reset request
    logic pll_rst;      // to PLL RST pin, active-high
    logic sys_reset;    // system reset, active-high
    logic ready;        // high only while running
`ifdef PLL_RSTSEQ_STATUS_EN
    logic [STATUS_W-1:0] retry_count;
    logic [STATUS_W-1:0] loss_count;

    modport master (
        input  pll_locked, rst_req,
        output pll_rst, sys_reset, ready, retry_count, loss_count
    );
    modport slave (
        output pll_locked, rst_req,
        input  pll_rst, sys_reset, ready, retry_count, loss_count
    );
`else
    modport master (
        input  pll_locked, rst_req,
        output pll_rst, sys_reset, ready
    );
    modport slave (
        output pll_locked, rst_req,
        input  pll_rst, sys_reset, ready
    );
`endif

endinterface

// File: rtl/pll_reset_sequencer_bit_sync.sv
// N-stage single-bit synchronizer, asynchronous active-low reset to 0.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the asynchronous input one stage further down the chain each cycle.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchronizer flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, qualifies the synchronized
// lock flag with a glitch filter, retries on lock timeout and releases a
// clean active-high system reset after a hold period.
// Define PLL_RSTSEQ_STATUS_EN to add saturating retry / loss counters.
module pll_reset_sequencer
    import pll_rstseq_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_FILTER    = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int HOLD_CYCLES    = 1024
) (
    input logic                   clock,
    input logic                   reset_n,
    pll_reset_sequencer_if.master bus
);

    localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_FILTER, LOCK_TIMEOUT, HOLD_CYCLES);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] FILTER_LAST  = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] filt_q, filt_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_reset_q, sys_reset_d;
    logic             ready_q, ready_d;
    logic             locked_s;
`ifdef PLL_RSTSEQ_STATUS_EN
    logic                retry_inc, loss_inc;
    logic [STATUS_W-1:0] retry_q, retry_d;
    logic [STATUS_W-1:0] loss_q, loss_d;
`endif

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (bus.pll_locked),
        .q       (locked_s)
    );

    // Next-state, counter updates and output decode from the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        filt_d  = filt_q;
`ifdef PLL_RSTSEQ_STATUS_EN
        retry_inc = 1'b0;
        loss_inc  = 1'b0;
`endif
        case (state_q)
            PLL_RST: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    filt_d  = '0;
                end
            end
            WAIT_LOCK: begin
                cnt_d  = cnt_q + 1'b1;
                filt_d = locked_s ? (filt_q + 1'b1) : '0;
                // A lock accepted on the same cycle as the timeout wins.
                if (locked_s && (filt_q == FILTER_LAST)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
`ifdef PLL_RSTSEQ_STATUS_EN
                    retry_inc = 1'b1;
`endif
                end
            end
            HOLD: begin
                cnt_d = cnt_q + 1'b1;
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    filt_d  = '0;
                end else if (bus.rst_req) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    // Lock lost: re-qualify without resetting the PLL; the
                    // timeout window restarts from zero.
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    filt_d  = '0;
`ifdef PLL_RSTSEQ_STATUS_EN
                    loss_inc = 1'b1;
`endif
                end else if (bus.rst_req) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
                filt_d  = '0;
            end
        endcase
        pll_rst_d   = (state_d == PLL_RST);
        sys_reset_d = (state_d != RUN);
        ready_d     = (state_d == RUN);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            filt_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            filt_q      <= filt_d;
            pll_rst_q   <= pll_rst_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.sys_reset = sys_reset_q;
    assign bus.ready     = ready_q;

`ifdef PLL_RSTSEQ_STATUS_EN
    // Saturating retry / loss counters; only reset_n clears them.
    always_comb begin
        retry_d = retry_q;
        loss_d  = loss_q;
        if (retry_inc && (retry_q != {STATUS_W{1'b1}})) begin
            retry_d = retry_q + 1'b1;
        end
        if (loss_inc && (loss_q != {STATUS_W{1'b1}})) begin
            loss_d = loss_q + 1'b1;
        end
    end

    // Status counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            retry_q <= retry_d;
            loss_q  <= loss_d;
        end
    end

    assign bus.retry_count = retry_q;
    assign bus.loss_count  = loss_q;
`endif

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Sits directly downstream of the ECP5 EHXPLLL wrapper that generates the 75/25 MHz clocks. Runs on the board reference clock, which is not a PLL output. Drives the PLL RST pin, then qualifies the asynchronous PLL `locked` flag: synchronizes it, glitch-filters it, retries on lock timeout, and releases a clean active-high `sys_reset` after a hold period. Consumer domains re-synchronize `sys_reset` locally.

Parameters:
- SYNC_STAGES, 2: flops in the `pll_locked` synchronizer (>=2).
- PLL_RST_CYCLES, 16: cycles `pll_rst` is held high per reset attempt.
- LOCK_FILTER, 16: consecutive synchronized-high cycles of `locked` required to accept lock.
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before the PLL is reset again.
- HOLD_CYCLES, 1024: cycles `sys_reset` stays asserted after lock is accepted.
- CNT_W, derived: clog2 of the largest count parameter, plus 1. Localparam, not overridable.

Ports:
- clock, input, 1: board reference clock (25 MHz).
- reset_n, input, 1: reset, asynchronous assert, active-low.
- pll_locked, input, 1: PLL LOCK; asynchronous to `clock`.
- rst_req, input, 1: synchronous single-cycle soft-reset request.
- pll_rst, output, 1: to PLL RST, active-high.
- sys_reset, output, 1: system reset, active-high, registered.
- ready, output, 1: high only in RUN.
- retry_count, output, 8: only with PLL_RSTSEQ_STATUS_EN.
- loss_count, output, 8: only with PLL_RSTSEQ_STATUS_EN.

Behaviour:
- Reset values while reset_n=0:
  - state=PLL_RST
  - pll_rst=1, sys_reset=1, ready=0
  - all counters 0, synchronizer flops 0
- `locked_s` is `pll_locked` after SYNC_STAGES flops. All decisions use `locked_s` only.
- All outputs are registered and decoded from next_state, so they change on the same edge as the state:
  - pll_rst = (state==PLL_RST)
  - sys_reset = (state!=RUN)
  - ready = (state==RUN)
- PLL_RST:
  - cnt increments each cycle.
  - At cnt==PLL_RST_CYCLES-1: go to WAIT_LOCK, clear cnt and filt.
- WAIT_LOCK:
  - cnt increments each cycle.
  - filt increments while locked_s=1 and clears to 0 when locked_s=0.
  - At filt==LOCK_FILTER-1 with locked_s=1: go to HOLD, clear cnt. Lock acceptance has priority over timeout in the same cycle.
  - Otherwise at cnt==LOCK_TIMEOUT-1: go to PLL_RST, clear cnt, increment the retry counter.
- HOLD:
  - cnt increments each cycle.
  - locked_s=0: go to WAIT_LOCK, clear cnt and filt.
  - Else rst_req=1: stay in HOLD, clear cnt.
  - Else at cnt==HOLD_CYCLES-1: go to RUN.
  - Result: with no disturbance, sys_reset falls exactly HOLD_CYCLES cycles after HOLD is entered.
- RUN:
  - locked_s=0: go to WAIT_LOCK, clear filt, increment the loss counter. sys_reset rises on that same edge. This has priority over rst_req.
  - Else rst_req=1: go to HOLD, clear cnt. The PLL is not reset.
- rst_req is ignored in PLL_RST and WAIT_LOCK.
- Counter width and saturation:
  - cnt and filt are CNT_W bits and never wrap; the terminal compare exits the state first.
  - retry and loss counters saturate at 255.
- reset_n asserted in any state forces the reset values immediately (asynchronous).
- Deassertion of reset_n is assumed synchronized externally.

Optional Feature:
- Macro: PLL_RSTSEQ_STATUS_EN.
- Defined: `retry_count` and `loss_count` ports exist. Both are 8-bit saturating counters, reset to 0 only by reset_n; soft reset and retries do not clear them.
- Undefined: neither port nor the counters exist, and the state machine is unchanged.

Decomposition:
- Package pll_rstseq_pkg holds:
  - state enum: PLL_RST=0, WAIT_LOCK=1, HOLD=2, RUN=3 (2 bits)
  - STATUS_W=8
  - the CNT_W helper function
- One sub-module: bit_sync, a parameterized N-stage single-bit synchronizer with async active-low reset to 0. It is used for `pll_locked`.

Test Plan:
Parameters for all tests: PLL_RST_CYCLES=4, LOCK_FILTER=8, HOLD_CYCLES=16, LOCK_TIMEOUT=64, SYNC_STAGES=2.
1. Release reset_n, then raise pll_locked at cycle 10 and hold it high. Expect:
   - pll_rst high for cycles 1-4
   - sys_reset falls 2 (sync) + 8 (filter) + 16 (hold) cycles after the rise
   - ready=1 from that same edge
2. Keep pll_locked=0. Expect:
   - pll_rst re-pulses every 68 cycles
   - retry_count = 1, 2, 3…
   - sys_reset stays 1
3. Glitch: pll_locked high for 5 cycles, low for 1, then high. Expect the filter to restart and HOLD to be entered only 8 synchronized-high cycles after the final rise.
4. In RUN, drop pll_locked for 1 cycle. Expect:
   - sys_reset=1 and ready=0 three edges later
   - loss_count=1
   - full filter + hold sequence before ready returns; pll_rst stays 0
5. In RUN, pulse rst_req. Expect sys_reset high for exactly 16 cycles, pll_rst stays 0, counters unchanged. Pulse rst_req at HOLD cnt=10 and expect the hold to restart.
6. Assert reset_n mid-HOLD. Expect pll_rst=1, sys_reset=1, ready=0 immediately without a clock edge, and status counters at 0.
